// File: rtl/time_digit_counter.sv
// 12-hour BCD time-of-day keeper with a manual set mode and blinking digits.
// Each output position is a 4-bit code for a 7-segment converter (4'hF = blank).
module time_digit_counter #(
    parameter int SEC_PER_MIN = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       set_mode,
    input  logic       inc_min,
    input  logic       inc_hour,
    output logic [3:0] hour_tens,
    output logic [3:0] hour_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] ampm,
    output logic       min_pulse
);

    localparam logic [7:0] SEC_LAST = 8'(SEC_PER_MIN - 1);
    localparam logic [3:0] BLANK    = 4'hF;

    logic [7:0] sec_cnt;
    logic [3:0] mt_r, mo_r, ho_r;
    logic       ht_r;   // hour tens is only ever 0 or 1
    logic       pm;
    logic       blink;

    logic [3:0] mt_inc, mo_inc, ho_inc;
    logic       ht_inc, pm_inc, hour_carry;

    // Next minute and next hour values, shared by run-mode rollover and set-mode buttons.
    always_comb begin
        mo_inc     = (mo_r == 4'd9) ? 4'd0 : mo_r + 4'd1;
        mt_inc     = mt_r;
        if (mo_r == 4'd9) begin
            mt_inc = (mt_r == 4'd5) ? 4'd0 : mt_r + 4'd1;
        end
        hour_carry = (mo_r == 4'd9) && (mt_r == 4'd5);

        ht_inc = ht_r;
        ho_inc = ho_r + 4'd1;
        pm_inc = pm;
        if (ht_r && ho_r == 4'd2) begin
            ht_inc = 1'b0;
            ho_inc = 4'd1;
        end else if (ho_r == 4'd9) begin
            ht_inc = 1'b1;
            ho_inc = 4'd0;
        end else if (ht_r && ho_r == 4'd1) begin
            pm_inc = ~pm;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sec_cnt   <= 8'd0;
            mt_r      <= 4'd0;
            mo_r      <= 4'd0;
            ht_r      <= 1'b1;
            ho_r      <= 4'd2;
            pm        <= 1'b0;
            blink     <= 1'b1;
            min_pulse <= 1'b0;
        end else if (set_mode) begin
            sec_cnt   <= 8'd0;
            min_pulse <= 1'b0;
            if (sec_tick) begin
                blink <= ~blink;
            end
            // Manual minute advance wraps 59 -> 00 without touching the hour.
            if (inc_min) begin
                mo_r <= mo_inc;
                mt_r <= mt_inc;
            end
            if (inc_hour) begin
                ht_r <= ht_inc;
                ho_r <= ho_inc;
                pm   <= pm_inc;
            end
        end else begin
            blink     <= 1'b1;
            min_pulse <= 1'b0;
            if (sec_tick) begin
                if (sec_cnt == SEC_LAST) begin
                    sec_cnt   <= 8'd0;
                    min_pulse <= 1'b1;
                    mo_r      <= mo_inc;
                    mt_r      <= mt_inc;
                    if (hour_carry) begin
                        ht_r <= ht_inc;
                        ho_r <= ho_inc;
                        pm   <= pm_inc;
                    end
                end else begin
                    sec_cnt <= sec_cnt + 8'd1;
                end
            end
        end
    end

    assign hour_tens = (!blink || !ht_r) ? BLANK : 4'd1;
    assign hour_ones = blink ? ho_r : BLANK;
    assign min_tens  = blink ? mt_r : BLANK;
    assign min_ones  = blink ? mo_r : BLANK;
    assign ampm      = pm ? 4'hB : 4'hA;

endmodule
